// File: rtl/ser_demux_pkg.sv
// Shared types and helpers for the serial frame demultiplexer.
package ser_demux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PORT,
        COUNT,
        DATA,
        PARITY,
        DONE
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/ser_demux_n_seg7.sv
// Hex nibble to active-high seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_seg7 (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = '0;
        case (hex_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            default: seg_o = 7'h71;
        endcase
    end

endmodule

// File: rtl/ser_demux_n.sv
// Serial frame receiver: start bit, port field, length field, data bits and
// optional even parity; data bits are routed to the addressed output port.
module ser_demux_n
    import ser_demux_pkg::*;
#(
    parameter int unsigned NPORT  = 4,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned PAR_EN = 1,
    localparam int unsigned PSEL_W = clog2(NPORT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              SerIn,
    output logic [NPORT-1:0]  p,
    output logic              serOutvalid,
    output logic [PSEL_W-1:0] port_num,
    output logic [CNT_W-1:0]  cnt_rem,
    output logic [6:0]        pDcnt,
    output logic              Done,
    output logic              par_err
);

    localparam int unsigned FLD_MAX = (PSEL_W > CNT_W) ? PSEL_W : CNT_W;
    localparam int unsigned BC_W    = (clog2(FLD_MAX) > 0) ? clog2(FLD_MAX) : 1;
    localparam logic [BC_W-1:0] PORT_LAST  = BC_W'(PSEL_W - 1);
    localparam logic [BC_W-1:0] COUNT_LAST = BC_W'(CNT_W - 1);
    localparam state_t TAIL = (PAR_EN != 0) ? PARITY : DONE;

    state_t            state_q, state_d;
    logic [NPORT-1:0]  p_q, p_d;
    logic              valid_q, valid_d;
    logic [PSEL_W-1:0] port_q, port_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;

    logic [PSEL_W-1:0] port_shift;
    logic [CNT_W-1:0]  cnt_shift;
    logic [3:0]        cnt_nib;

    assign port_shift = PSEL_W'({port_q, SerIn});
    assign cnt_shift  = CNT_W'({cnt_q, SerIn});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            valid_q <= 1'b0;
            port_q  <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            valid_q <= valid_d;
            port_q  <= port_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        valid_d = 1'b0;
        port_d  = port_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        perr_d  = perr_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (bit_en && !SerIn) begin
                    state_d = PORT;
                    bcnt_d  = '0;
                    par_d   = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            PORT: begin
                if (bit_en) begin
                    port_d = port_shift;
                    if (bcnt_q == PORT_LAST) begin
                        bcnt_d  = '0;
                        state_d = COUNT;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            COUNT: begin
                // Exit decision uses the length including the bit shifted in now.
                if (bit_en) begin
                    cnt_d = cnt_shift;
                    if (bcnt_q == COUNT_LAST) begin
                        bcnt_d  = '0;
                        state_d = (cnt_shift != '0) ? DATA : TAIL;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_en) begin
                    p_d         = '0;
                    p_d[port_q] = SerIn;
                    valid_d     = 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                    par_d       = par_q ^ SerIn;
                    if (cnt_q == CNT_W'(1)) state_d = TAIL;
                end
            end
            PARITY: begin
                if (bit_en) begin
                    perr_d  = par_q ^ SerIn;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    generate
        if (CNT_W >= 4) begin : g_nib_wide
            assign cnt_nib = cnt_q[3:0];
        end else begin : g_nib_narrow
            assign cnt_nib = {{(4 - CNT_W){1'b0}}, cnt_q};
        end
    endgenerate

    hex_to_seg7 u_seg7 (
        .hex_i (cnt_nib),
        .seg_o (pDcnt)
    );

    assign p           = p_q;
    assign serOutvalid = valid_q;
    assign port_num    = port_q;
    assign cnt_rem     = cnt_q;
    assign Done        = (state_q == DONE);
    assign par_err     = (state_q == DONE) && perr_q;

endmodule
